// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// Module   : ram_fifo_pkg
// Purpose  : Shared widths and helpers for the RAM-backed FIFO controller.
// Contents : DATA_W, ADDR_W, DEPTH, CNT_W, pointer type, occupancy().
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [CNT_W-1:0] ptr_t;

  // Occupancy is the modulo-128 distance from read to write pointer.
  function automatic ptr_t occupancy(input ptr_t wr, input ptr_t rd);
    return ptr_t'(wr - rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_single_port.sv
// ============================================================================
// Module   : ram_single_port
// Purpose  : 64x8 storage, one write port, read through a registered address.
// Ports    : clk        - clock
//            we         - write enable
//            write_addr - write address
//            read_addr  - read address, captured every rising edge
//            data       - write data
//            q          - mem[read_addr_reg]
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_single_port
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] read_addr_reg;

  // Storage and the read address register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[write_addr] <= data;
    end
    read_addr_reg <= read_addr;
  end

  // Combinational read after the registered address: a word written at an
  // edge is visible on q right after that edge if the address matches.
  assign q = mem[read_addr_reg];

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module   : ram_fifo_ctrl
// Purpose  : 64-entry, 8-bit valid/ready FIFO on a single-port RAM, with
//            status flags and an occupancy high-water mark.
// Ports    : clk, rst_n (async active-low), flush (sync clear)
//            in_data/in_valid/in_ready    - write side
//            out_data/out_valid/out_ready - read side
//            count, full, empty, almost_full, almost_empty - status
//            peak, peak_clr               - high-water mark and its clear
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned AFULL_LEVEL  = 48,
  parameter int unsigned AEMPTY_LEVEL = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  peak,
  input  logic              peak_clr
);

  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  ptr_t              wr_next;
  ptr_t              rd_next;
  ptr_t              next_count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] ram_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = occupancy(wr_ptr, rd_ptr);

  // in_ready is computed from the current full flag only, so a pop in the
  // same cycle never opens a slot for a pass-through write.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (push) begin
      wr_next = wr_ptr + 1'b1;
    end
    // Flush wins over pop; push is already masked through in_ready.
    if (flush) begin
      rd_next = wr_ptr;
    end else if (pop) begin
      rd_next = rd_ptr + 1'b1;
    end
  end

  assign next_count = occupancy(wr_next, rd_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      peak   <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (peak_clr) begin
        peak <= next_count;
      end else if (next_count > peak) begin
        peak <= next_count;
      end
    end
  end

  assign almost_full  = (count >= CNT_W'(AFULL_LEVEL));
  assign almost_empty = (count <= CNT_W'(AEMPTY_LEVEL));

  // Reading from the next head address keeps the RAM's registered address
  // equal to the head after every edge (including the flush case, where the
  // new head is the current write pointer).
  ram_single_port u_ram (
    .clk        (clk),
    .we         (push),
    .write_addr (wr_ptr[ADDR_W-1:0]),
    .read_addr  (rd_next[ADDR_W-1:0]),
    .data       (in_data),
    .q          (ram_q)
  );

  assign out_data = out_valid ? ram_q : '0;

endmodule

`default_nettype wire
